// File: rtl/conv_window_sequencer_if.sv
// Bundle of the start/status, buffer-read and ofmap-output signals of conv_window_sequencer.
// master is the sequencer side, slave is the buffers/ofmap-writer side.
interface conv_window_sequencer_if #(
  parameter int IFMAP_SIZE  = 5,
  parameter int FILTER_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int DATA_WIDTH  = 8
);
  localparam int OFMAP_SIZE = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int IA_W = (IFMAP_SIZE * IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE * IFMAP_SIZE) : 1;
  localparam int FA_W = (FILTER_SIZE * FILTER_SIZE > 1) ? $clog2(FILTER_SIZE * FILTER_SIZE) : 1;
  localparam int OI_W = (OFMAP_SIZE * OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE * OFMAP_SIZE) : 1;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [IA_W-1:0]       ifmap_addr;
  logic [FA_W-1:0]       filter_addr;
  logic [DATA_WIDTH-1:0] pix_data;
  logic [DATA_WIDTH-1:0] wgt_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [OI_W-1:0]       out_idx;

  modport master (
    input  start, pix_data, wgt_data, out_ready,
    output busy, done, rd_en, ifmap_addr, filter_addr, out_valid, out_data, out_idx
  );

  modport slave (
    output start, pix_data, wgt_data, out_ready,
    input  busy, done, rd_en, ifmap_addr, filter_addr, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Walks every filter window of one ifmap, issues one buffer read per tap, accumulates the products
// and hands each output pixel downstream. CONV_SEQ_SAT_EN selects saturating instead of wrapping output.
module conv_window_sequencer #(
  parameter int IFMAP_SIZE  = 5,
  parameter int FILTER_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_window_sequencer_if.master bus
);
  localparam int OFMAP_SIZE = (IFMAP_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int K2         = FILTER_SIZE * FILTER_SIZE;
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(K2);
  localparam int PW         = 2 * DATA_WIDTH;
  localparam int IA_W = (IFMAP_SIZE * IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE * IFMAP_SIZE) : 1;
  localparam int FA_W = (K2 > 1) ? $clog2(K2) : 1;
  localparam int OI_W = (OFMAP_SIZE * OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE * OFMAP_SIZE) : 1;
  localparam int FC_W = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int OC_W = (OFMAP_SIZE > 1) ? $clog2(OFMAP_SIZE) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [FC_W-1:0]       fr_q, fr_d, fc_q, fc_d;
  logic [OC_W-1:0]       wr_q, wr_d, wc_q, wc_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [OI_W-1:0]       out_idx_q, out_idx_d;
  logic [PW-1:0]         prod;
  logic [DATA_WIDTH-1:0] res;
  logic                  tap_last, win_last;

  assign prod     = PW'(bus.pix_data) * PW'(bus.wgt_data);
  assign tap_last = (fr_q == FC_W'(FILTER_SIZE - 1)) && (fc_q == FC_W'(FILTER_SIZE - 1));
  assign win_last = (wr_q == OC_W'(OFMAP_SIZE - 1)) && (wc_q == OC_W'(OFMAP_SIZE - 1));

  always_comb begin
`ifdef CONV_SEQ_SAT_EN
    res = (acc_d > ACC_WIDTH'((1 << DATA_WIDTH) - 1)) ? {DATA_WIDTH{1'b1}} : acc_d[DATA_WIDTH-1:0];
`else
    res = acc_d[DATA_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d    = state_q;
    fr_d       = fr_q;
    fc_d       = fc_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    // Read data lands one cycle after its strobe, so the add trails the read by one cycle.
    acc_d      = rd_vld_q ? acc_q + ACC_WIDTH'(prod) : acc_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          fr_d    = '0;
          fc_d    = '0;
          wr_d    = '0;
          wc_d    = '0;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        // The tap counters stop on the last tap so the addresses hold until the next window.
        if (tap_last) begin
          state_d = S_DRAIN;
        end else if (fc_q == FC_W'(FILTER_SIZE - 1)) begin
          fc_d = '0;
          fr_d = fr_q + 1'b1;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d    = S_OUT;
        out_data_d = res;
        out_idx_d  = OI_W'(int'(wr_q) * OFMAP_SIZE + int'(wc_q));
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (win_last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            fr_d    = '0;
            fc_d    = '0;
            acc_d   = '0;
            if (wc_q == OC_W'(OFMAP_SIZE - 1)) begin
              wc_d = '0;
              wr_d = wr_q + 1'b1;
            end else begin
              wc_d = wc_q + 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fr_q       <= '0;
      fc_q       <= '0;
      wr_q       <= '0;
      wc_q       <= '0;
      acc_q      <= '0;
      rd_vld_q   <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      fr_q       <= fr_d;
      fc_q       <= fc_d;
      wr_q       <= wr_d;
      wc_q       <= wc_d;
      acc_q      <= acc_d;
      rd_vld_q   <= (state_q == S_RUN);
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.rd_en       = (state_q == S_RUN);
  assign bus.out_valid   = (state_q == S_OUT);
  assign bus.out_data    = out_data_q;
  assign bus.out_idx     = out_idx_q;
  assign bus.ifmap_addr  = IA_W'((int'(wr_q) * STRIDE + int'(fr_q)) * IFMAP_SIZE
                                 + int'(wc_q) * STRIDE + int'(fc_q));
  assign bus.filter_addr = FA_W'(int'(fr_q) * FILTER_SIZE + int'(fc_q));
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: a stride-1 and a stride-2 instance read shared ifmap/filter
// memories; outputs are compared against a direct sum-of-products reference.
module tb_conv_window_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_sequencer_if #(.IFMAP_SIZE(5), .FILTER_SIZE(3), .STRIDE(1), .DATA_WIDTH(8)) if0 ();
  conv_window_sequencer_if #(.IFMAP_SIZE(5), .FILTER_SIZE(3), .STRIDE(2), .DATA_WIDTH(8)) if1 ();

  conv_window_sequencer #(.IFMAP_SIZE(5), .FILTER_SIZE(3), .STRIDE(1), .DATA_WIDTH(8)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  conv_window_sequencer #(.IFMAP_SIZE(5), .FILTER_SIZE(3), .STRIDE(2), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  logic [7:0] pix_mem [25];
  logic [7:0] wgt_mem [9];

  // Buffers with 1-cycle read latency; junk on the data bus when no read was issued.
  always @(posedge clk) begin
    if (if0.rd_en) begin
      if0.pix_data <= pix_mem[if0.ifmap_addr];
      if0.wgt_data <= wgt_mem[if0.filter_addr];
    end else begin
      if0.pix_data <= 8'($urandom);
      if0.wgt_data <= 8'($urandom);
    end
    if (if1.rd_en) begin
      if1.pix_data <= pix_mem[if1.ifmap_addr];
      if1.wgt_data <= wgt_mem[if1.filter_addr];
    end else begin
      if1.pix_data <= 8'($urandom);
      if1.wgt_data <= 8'($urandom);
    end
  end

  int got_d0[$], got_i0[$], hs0[$], ra0[$], fa0[$];
  int got_d1[$], got_i1[$], hs1[$], ra1[$], fa1[$];
  int first_v0 = -1, done_cnt0 = 0, done_cnt1 = 0;

  always @(negedge clk) begin
    if (if0.out_valid && if0.out_ready) begin
      got_d0.push_back(int'(if0.out_data));
      got_i0.push_back(int'(if0.out_idx));
      hs0.push_back(cyc);
      $display("dut0 out idx=%0d data=%0d cycle=%0d", if0.out_idx, if0.out_data, cyc);
    end
    if (if0.out_valid && first_v0 < 0) first_v0 = cyc;
    if (if0.done) done_cnt0++;
    if (if0.rd_en) begin
      ra0.push_back(int'(if0.ifmap_addr));
      fa0.push_back(int'(if0.filter_addr));
    end
    if (if1.out_valid && if1.out_ready) begin
      got_d1.push_back(int'(if1.out_data));
      got_i1.push_back(int'(if1.out_idx));
      hs1.push_back(cyc);
      $display("dut1 out idx=%0d data=%0d cycle=%0d", if1.out_idx, if1.out_data, cyc);
    end
    if (if1.done) done_cnt1++;
    if (if1.rd_en) begin
      ra1.push_back(int'(if1.ifmap_addr));
      fa1.push_back(int'(if1.filter_addr));
    end
  end

  // Reference: plain sum of pixel*weight over the window, then saturate or wrap to 8 bits.
  function automatic int ref_out(input int s, input int wr, input int wc);
    int acc = 0;
    for (int fr = 0; fr < 3; fr++)
      for (int fc = 0; fc < 3; fc++)
        acc += int'(pix_mem[(wr * s + fr) * 5 + wc * s + fc]) * int'(wgt_mem[fr * 3 + fc]);
`ifdef CONV_SEQ_SAT_EN
    if (acc > 255) acc = 255;
`else
    acc = acc % 256;
`endif
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 25; i++) pix_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic start0();
    got_d0.delete(); got_i0.delete(); hs0.delete(); ra0.delete(); fa0.delete();
    first_v0  = -1;
    done_cnt0 = 0;
    tick();
    if0.start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    chk("start_busy_pre", if0.busy, 0);
    tick();
    if0.start = 1'b0;
    @(negedge clk);
    chk("start_busy_rd", {if0.busy, if0.rd_en}, 2'b11);
  endtask

  task automatic wait_done0(input bit rnd);
    int n = 0;
    while (done_cnt0 == 0 && n < 3000) begin
      if0.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if0.out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic check_map(input string tag, input int s, input int gd[$], input int gi[$],
                           input int ra[$], input int fa[$], input int dn);
    int os  = (5 - 3) / s + 1;
    int bad = 0;
    chk({tag, "_count"}, gd.size(), os * os);
    for (int n = 0; n < gd.size() && n < os * os; n++) begin
      chk($sformatf("%s_data%0d", tag, n), gd[n], ref_out(s, n / os, n % os));
      chk($sformatf("%s_idx%0d", tag, n), gi[n], n);
    end
    chk({tag, "_reads"}, ra.size(), os * os * 9);
    for (int r = 0; r < ra.size(); r++) begin
      int w = r / 9;
      int t = r % 9;
      if (ra[r] != ((w / os) * s + t / 3) * 5 + (w % os) * s + t % 3 || fa[r] != t) bad++;
    end
    chk({tag, "_addr_seq"}, bad, 0);
    chk({tag, "_done"}, dn, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int basic_exp[9] = '{63, 72, 81, 108, 117, 126, 153, 162, 171};
    int n, d, i, bad;

    rst = 1'b1;
    if0.start = 1'b0; if0.out_ready = 1'b0;
    if1.start = 1'b0; if1.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs0", {if0.busy, if0.done, if0.rd_en, if0.ifmap_addr, if0.filter_addr,
                        if0.out_valid, if0.out_data, if0.out_idx}, 0);
    chk("reset_outs1", {if1.busy, if1.done, if1.rd_en, if1.ifmap_addr, if1.filter_addr,
                        if1.out_valid, if1.out_data, if1.out_idx}, 0);
    tick();
    rst = 1'b0;

    // Basic map: ifmap 1..25, filter all ones.
    for (int k = 0; k < 25; k++) pix_mem[k] = 8'(k + 1);
    for (int k = 0; k < 9; k++)  wgt_mem[k] = 8'd1;
    if0.out_ready = 1'b1;
    start0();
    wait_done0(0);
    check_map("basic", 1, got_d0, got_i0, ra0, fa0, done_cnt0);
    for (int k = 0; k < got_d0.size() && k < 9; k++)
      chk($sformatf("basic_const%0d", k), got_d0[k], basic_exp[k]);
    chk("first_valid_lat", first_v0 - c0, 11);
    if (hs0.size() >= 2) chk("hs_period", hs0[1] - hs0[0], 11);

    // Random data with random backpressure.
    for (int it = 0; it < 2; it++) begin
      fill_rand();
      start0();
      wait_done0(1);
      check_map($sformatf("rnd%0d", it), 1, got_d0, got_i0, ra0, fa0, done_cnt0);
    end

    // All pixels at full scale.
    for (int k = 0; k < 25; k++) pix_mem[k] = 8'd255;
    for (int k = 0; k < 9; k++)  wgt_mem[k] = 8'd1;
    start0();
    wait_done0(0);
    check_map("sat", 1, got_d0, got_i0, ra0, fa0, done_cnt0);
`ifdef CONV_SEQ_SAT_EN
    chk("sat_val", got_d0[0], 255);
`else
    chk("sat_val", got_d0[0], 247);
`endif

    // Backpressure on the first output.
    fill_rand();
    if0.out_ready = 1'b0;
    start0();
    n = 0;
    while (!if0.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach", if0.out_valid, 1);
    d = int'(if0.out_data);
    i = int'(if0.out_idx);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!if0.out_valid || int'(if0.out_data) != d || int'(if0.out_idx) != i || if0.rd_en) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_idx0", i, 0);
    chk("bp_data0", d, ref_out(1, 0, 0));
    tick();
    if0.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_resume", {if0.rd_en, if0.out_valid}, 2'b10);
    wait_done0(0);
    check_map("bp", 1, got_d0, got_i0, ra0, fa0, done_cnt0);

    // start pulses while busy are ignored.
    fill_rand();
    start0();
    repeat (20) tick();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    repeat (40) tick();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
    wait_done0(0);
    check_map("busy_start", 1, got_d0, got_i0, ra0, fa0, done_cnt0);
    repeat (10) tick();
    @(negedge clk);
    chk("no_restart_busy", if0.busy, 0);
    chk("no_restart_count", got_d0.size(), 9);

    // Reset in the RUN of window 4.
    fill_rand();
    start0();
    n = 0;
    while (got_d0.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    tick();
    chk("rst_in_run", if0.rd_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {if0.busy, if0.done, if0.rd_en, if0.ifmap_addr, if0.filter_addr,
                         if0.out_valid, if0.out_data, if0.out_idx}, 0);
    repeat (20) tick();
    chk("rst_no_done", done_cnt0, 0);
    chk("rst_no_valid", got_d0.size(), 4);
    start0();
    wait_done0(0);
    check_map("after_rst", 1, got_d0, got_i0, ra0, fa0, done_cnt0);

    // Stride-2 instance.
    fill_rand();
    got_d1.delete(); got_i1.delete(); hs1.delete(); ra1.delete(); fa1.delete();
    done_cnt1 = 0;
    tick();
    if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    n = 0;
    while (done_cnt1 == 0 && n < 2000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_map("s2", 2, got_d1, got_i1, ra1, fa1, done_cnt1);
    chk("s2_w3_tap0", ra1[27], 12);
    chk("s2_w3_tap8", ra1[35], 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Controller that sequences the convolution MAC datapath over one input feature map. On `start` it walks every filter-window position in raster order and issues one ifmap/filter read per tap. It accumulates the returned products and hands each finished output pixel downstream with a valid/ready handshake. It sits between the ifmap/filter buffers (synchronous read, 1-cycle latency) and the ofmap writer.

## Interface
- `IFMAP_SIZE`, default 5: ifmap edge length.
- `FILTER_SIZE`, default 3: filter edge length K.
- `STRIDE`, default 1: window step, horizontal and vertical.
- `DATA_WIDTH`, default 8: pixel, weight and output width, unsigned.
- Derived, not overridable:
  - `OFMAP_SIZE = (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1`.
  - `ACC_WIDTH = 2*DATA_WIDTH + $clog2(FILTER_SIZE*FILTER_SIZE)`.
- Legal configurations only: `(IFMAP_SIZE-FILTER_SIZE) % STRIDE == 0` and `FILTER_SIZE <= IFMAP_SIZE`.
- `clk` in 1: clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request to begin one full feature map.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last output is accepted.
- `rd_en` out 1: read strobe to both buffers.
- `ifmap_addr` out `$clog2(IFMAP_SIZE*IFMAP_SIZE)`: row-major pixel address.
- `filter_addr` out `$clog2(FILTER_SIZE*FILTER_SIZE)`: tap index.
- `pix_data` in `DATA_WIDTH`: ifmap read data, valid 1 cycle after `rd_en`.
- `wgt_data` in `DATA_WIDTH`: filter read data, valid 1 cycle after `rd_en`.
- `out_valid` out 1: output pixel available.
- `out_ready` in 1: downstream accepts the output pixel.
- `out_data` out `DATA_WIDTH`: output pixel value.
- `out_idx` out `$clog2(OFMAP_SIZE*OFMAP_SIZE)`: raster index of the output pixel.

## Operation
- FSM states:
  - IDLE: `start` moves to RUN, window (0,0), tap 0, accumulator cleared.
  - RUN: issues taps 0..K*K-1 with `rd_en=1`, then moves to DRAIN.
  - DRAIN: lasts 1 cycle, absorbs the last product, then moves to OUT.
  - OUT: holds `out_valid=1`. On `out_valid&&out_ready`, goes to DONE if this was the last window. Otherwise it advances to the next window, moves to RUN and clears the accumulator.
  - DONE: `done=1` for 1 cycle, then returns to IDLE.
- Tap t is split as `fr=t/K`, `fc=t%K`. Window (wr,wc):
  - `ifmap_addr = (wr*STRIDE+fr)*IFMAP_SIZE + wc*STRIDE+fc`.
  - `filter_addr = t`.
- Windows are visited in raster order: wc fastest, then wr. `out_idx = wr*OFMAP_SIZE+wc`.
- Product `pix_data*wgt_data` is computed at full 2*DATA_WIDTH width and added into an ACC_WIDTH accumulator on the cycle after each `rd_en`. The accumulator cannot overflow.
- `out_data` is derived from the accumulator per Configuration. It is registered and stable throughout OUT.
- `start` is ignored while `busy`. `out_ready` is ignored outside OUT.
- Outside RUN: `rd_en=0`, and `ifmap_addr`/`filter_addr` hold their last value.
- Reset: all state clears and the FSM goes to IDLE.
  - Reset value of every output is 0.
  - A reset mid-run abandons the map. No `done` is issued and no `out_valid` is issued for the partial window.

## Timing
- Start accepted in cycle c. The first `rd_en` is in c+1, and `busy` is high from c+1.
- Per window: K*K RUN cycles, 1 DRAIN cycle, then at least 1 OUT cycle. First `out_valid` is at c+K*K+2.
- With `out_ready` held high, outputs arrive every K*K+2 cycles.
- `done` follows the last handshake by 1 cycle. `start` may be accepted on the cycle after `done`.
- Backpressure stalls the FSM in OUT. There are no reads while stalled.

## Configuration
- `CONV_SEQ_SAT_EN` defined: `out_data` = accumulator saturated to `2^DATA_WIDTH-1`.
- `CONV_SEQ_SAT_EN` undefined: `out_data` = accumulator low `DATA_WIDTH` bits (wrap).

## Test plan
- Basic map, defaults, ifmap 1..25 row-major, filter all 1, `out_ready` high: 9 outputs 63,72,81,108,117,126,153,162,171 with `out_idx` 0..8, then one `done` pulse.
- Saturation, all pixels 255, filter all 1: `out_data`=255 with `CONV_SEQ_SAT_EN`; 247 (2295 mod 256) without it.
- `STRIDE`=2 on 5x5: 4 outputs. Window 3 tap 0 has `ifmap_addr`=12; tap 8 has `ifmap_addr`=24.
- Backpressure, `out_ready` low for 5 cycles in OUT: `out_valid`, `out_data` and `out_idx` stay stable and `rd_en` stays 0. Sequencing resumes 1 cycle after the handshake.
- `start` pulsed while busy: ignored, no restart, output count stays 9.
- `rst` in the RUN of window 4: the next cycle shows IDLE with all outputs 0 and no `done`. A fresh `start` produces all 9 correct outputs.
